// File: rtl/count_seq_checker.sv
// Reader-side checker for an enable-gated binary counter: predicts each next
// count from the previous sample and enable, and reports lock, mismatches and wraps.
module count_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int ERR_W    = 8,
  parameter int RESYNC_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             sticky_err,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] exp_count
);

  typedef enum logic [1:0] {UNSYNC, TRACK, FAULT} state_t;

  localparam logic [3:0] RESYNC_V = 4'(RESYNC_N);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] c, input logic e);
    return e ? c + WIDTH'(1) : c;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             prev_en_q, prev_en_d;
  logic [3:0]       good_run_q, good_run_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             sticky_q, sticky_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] exp_now;
  logic [3:0]       good_inc;
  logic             mismatch;

  always_comb begin
    exp_now      = predict(prev_count_q, prev_en_q);
    good_inc     = good_run_q + 4'd1;
    mismatch     = (state_q != UNSYNC) && (count_in != exp_now);
    state_d      = state_q;
    good_run_d   = good_run_q;
    err_cnt_d    = err_cnt_q;
    sticky_d     = sticky_q;
    err_pulse_d  = 1'b0;
    wrap_d       = 1'b0;
    prev_count_d = count_in;
    prev_en_d    = en;
    exp_d        = predict(count_in, en);

    case (state_q)
      UNSYNC: begin
        state_d    = TRACK;
        good_run_d = 4'd0;
      end
      TRACK, FAULT: begin
        if (mismatch) begin
          err_pulse_d = 1'b1;
          err_cnt_d   = sat_inc(err_cnt_q);
          sticky_d    = 1'b1;
          good_run_d  = 4'd0;
          state_d     = FAULT;
        end else begin
          wrap_d = prev_en_q && (&prev_count_q);
          // In FAULT, a run of consecutive good predictions re-establishes lock.
          if (state_q == FAULT) begin
            if (good_inc == RESYNC_V) begin
              state_d    = TRACK;
              good_run_d = 4'd0;
            end else begin
              good_run_d = good_inc;
            end
          end
        end
      end
      default: state_d = UNSYNC;
    endcase

    if (clr_err) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= UNSYNC;
      prev_count_q <= '0;
      prev_en_q    <= 1'b0;
      good_run_q   <= 4'd0;
      err_cnt_q    <= '0;
      sticky_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_q       <= 1'b0;
      exp_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= prev_count_d;
      prev_en_q    <= prev_en_d;
      good_run_q   <= good_run_d;
      err_cnt_q    <= err_cnt_d;
      sticky_q     <= sticky_d;
      err_pulse_q  <= err_pulse_d;
      wrap_q       <= wrap_d;
      exp_q        <= exp_d;
    end
  end

  assign locked     = (state_q == TRACK);
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign sticky_err = sticky_q;
  assign wrap_pulse = wrap_q;
  assign exp_count  = exp_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomized and directed bench for count_seq_checker against a sequence-level model.
module tb_count_seq_checker;

  localparam int WIDTH    = 3;
  localparam int ERR_W    = 2;
  localparam int RESYNC_N = 4;
  localparam int MODN     = 1 << WIDTH;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             clr_err = 1'b0;
  logic             locked, err_pulse, sticky_err, wrap_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [WIDTH-1:0] exp_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: what has been observed so far, in sequence terms.
  bit m_synced, m_fault, m_sticky, m_pulse, m_wrap;
  int m_last, m_last_en, m_good, m_err, m_exp;

  count_seq_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W), .RESYNC_N(RESYNC_N)) dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .sticky_err(sticky_err), .wrap_pulse(wrap_pulse), .exp_count(exp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model_vec();
    return {m_synced && !m_fault, m_pulse, ERR_W'(m_err), m_sticky, m_wrap, WIDTH'(m_exp)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {locked, err_pulse, err_cnt, sticky_err, wrap_pulse, exp_count};
  endfunction

  task automatic model_reset();
    m_synced = 0; m_fault = 0; m_sticky = 0; m_pulse = 0; m_wrap = 0;
    m_last = 0; m_last_en = 0; m_good = 0; m_err = 0; m_exp = 0;
  endtask

  task automatic tick(input logic e, input int c, input logic clr);
    int predicted;
    en = e; count_in = WIDTH'(c); clr_err = clr;
    @(posedge clk);
    m_pulse = 0; m_wrap = 0;
    if (!m_synced) begin
      m_synced = 1;
    end else begin
      predicted = (m_last + m_last_en) % MODN;
      if ((c % MODN) != predicted) begin
        m_pulse = 1; m_sticky = 1; m_good = 0; m_fault = 1;
        if (m_err < ERR_MAX) m_err++;
      end else begin
        m_wrap = (m_last_en == 1) && (m_last == MODN - 1);
        if (m_fault) begin
          m_good++;
          if (m_good == RESYNC_N) begin m_fault = 0; m_good = 0; end
        end
      end
    end
    if (clr) begin m_err = 0; m_sticky = 0; end
    m_last = c % MODN; m_last_en = int'(e); m_exp = (m_last + m_last_en) % MODN;
    #1;
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_vec() !== 9'd0) $display("FAIL reset_outputs got=%h want=000", dut_vec());
    else n_pass++;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
  endtask

  task automatic test_count_run();
    int wraps = 0;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick(1'b1, (k - 1) % MODN, 1'b0);
      n_checks++;
      if (wrap_pulse !== ((k == 9) || (k == 17))) $display("FAIL run_wrap k=%0d got=%b", k, wrap_pulse);
      else n_pass++;
      if (wrap_pulse === 1'b1) wraps++;
      if (locked !== 1'b1 || err_pulse !== 1'b0) begin
        n_checks++;
        $display("FAIL run_lock k=%0d locked=%b err_pulse=%b want 1/0", k, locked, err_pulse);
      end
    end
    n_checks++;
    if (err_cnt !== 0 || wraps != 2) $display("FAIL run_summary err_cnt=%0d wraps=%0d want 0/2", err_cnt, wraps);
    else n_pass++;
  endtask

  task automatic test_en_pattern();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int c = 0;
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(pat[i], c, 1'b0);
      if (err_pulse === 1'b1) pulses++;
      c = (c + int'(pat[i])) % MODN;
    end
    n_checks++;
    if (pulses != 0 || locked !== 1'b1 || exp_count !== 3'd3)
      $display("FAIL en_pattern pulses=%0d locked=%b exp=%0d want 0/1/3", pulses, locked, exp_count);
    else n_pass++;
  endtask

  task automatic test_skip();
    do_reset();
    for (int c = 0; c <= 2; c++) tick(1'b1, c, 1'b0);
    tick(1'b1, 4, 1'b0);
    n_checks++;
    if ({err_pulse, err_cnt, sticky_err, locked} !== {1'b1, 2'd1, 1'b1, 1'b0})
      $display("FAIL skip_detect got=%b%0d%b%b want pulse=1 cnt=1 sticky=1 locked=0",
               err_pulse, err_cnt, sticky_err, locked);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      tick(1'b1, (4 + i) % MODN, 1'b0);
      n_checks++;
      if (locked !== (i == 4) || err_pulse !== 1'b0)
        $display("FAIL skip_resync step=%0d locked=%b err_pulse=%b", i, locked, err_pulse);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int pulses = 0;
    do_reset();
    for (int c = 0; c <= 5; c++) tick(1'b1, c, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 5, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 3 || err_cnt !== 2'd3 || locked !== 1'b0)
      $display("FAIL stall pulses=%0d err_cnt=%0d locked=%b want 3/3/0", pulses, err_cnt, locked);
    else n_pass++;
    for (int i = 1; i <= 4; i++) tick(1'b1, (5 + i) % MODN, 1'b0);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL stall_resync locked=%b want 1", locked);
    else n_pass++;
  endtask

  task automatic test_saturate_clear();
    int pulses = 0;
    do_reset();
    tick(1'b0, 0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, k, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 6 || err_cnt !== 2'd3 || sticky_err !== 1'b1)
      $display("FAIL saturate pulses=%0d err_cnt=%0d sticky=%b want 6/3/1", pulses, err_cnt, sticky_err);
    else n_pass++;
    tick(1'b0, 7, 1'b1);
    n_checks++;
    if ({err_pulse, err_cnt, sticky_err} !== {1'b1, 2'd0, 1'b0})
      $display("FAIL clear_wins pulse=%b err_cnt=%0d sticky=%b want 1/0/0", err_pulse, err_cnt, sticky_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fault();
    do_reset();
    tick(1'b0, 0, 1'b0);
    tick(1'b0, 1, 1'b0);
    tick(1'b0, 2, 1'b0);
    n_checks++;
    if (err_cnt !== 2'd2 || locked !== 1'b0) $display("FAIL pre_reset err_cnt=%0d locked=%b want 2/0", err_cnt, locked);
    else n_pass++;
    do_reset();
    tick(1'b1, 6, 1'b0);
    tick(1'b1, 7, 1'b0);
    tick(1'b1, 0, 1'b0);
    n_checks++;
    if ({locked, err_pulse, err_cnt, sticky_err, wrap_pulse} !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b1})
      $display("FAIL post_reset got=%b%b%0d%b%b want locked=1 pulse=0 cnt=0 sticky=0 wrap=1",
               locked, err_pulse, err_cnt, sticky_err, wrap_pulse);
    else n_pass++;
  endtask

  task automatic test_random();
    int cnt = 0;
    int c;
    logic e, clr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        cnt = $urandom_range(0, MODN - 1);
      end
      e   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      c   = cnt;
      if ($urandom_range(0, 9) == 0) c = (cnt + $urandom_range(1, MODN - 1)) % MODN;
      tick(e, c, clr);
      cnt = (c + int'(e)) % MODN;
      n_checks++;
      if (dut_vec() !== model_vec())
        $display("FAIL random cyc=%0d got=%b want=%b (locked,pulse,cnt,sticky,wrap,exp)", i, dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count_run();
    test_en_pattern();
    test_skip();
    test_stall();
    test_saturate_clear();
    test_reset_mid_fault();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Reader-side companion to the enable-gated binary counters.
- Samples a counter's `count` bus and the `en` that drives it, predicts every next value, and flags skips, stalls and spurious steps.
- Reports lock status, mismatch pulses, a saturating error count and wrap events.
- Sits beside a counter instance in simulation and on-chip self-test of the fuzzy timebase.

Parameters:
- WIDTH, 3, width of the monitored count bus.
- ERR_W, 8, width of the saturating error counter.
- RESYNC_N, 4, consecutive correct predictions required to leave FAULT (1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  same enable the monitored counter samples.
- count_in  input  WIDTH  monitored counter output, registered in the clk domain.
- clr_err  input  1  synchronous clear of err_cnt and sticky_err.
- locked  output  1  high while state is TRACK.
- err_pulse  output  1  one-cycle pulse per detected mismatch.
- err_cnt  output  ERR_W  saturating mismatch count.
- sticky_err  output  1  set on first mismatch, held until clr_err or reset.
- wrap_pulse  output  1  one-cycle pulse on a correct all-ones to 0 step.
- exp_count  output  WIDTH  value predicted for the current cycle (debug).

Behaviour:
- Reset (rst=0, async): state=UNSYNC. All outputs 0. Internal prev_count=0, prev_en=0, good_run=0.
- Every edge out of reset registers prev_count<=count_in and prev_en<=en.
- Prediction: exp = prev_en ? prev_count+1 (mod 2^WIDTH) : prev_count. Compared combinationally against count_in.
- Response latency: a mismatch present at edge t appears on err_pulse in the cycle after edge t, i.e. one cycle after the bad count_in is visible.
- State UNSYNC: no checking. The first edge after reset release captures prev_* and moves to TRACK. locked stays 0 in that cycle.
- State TRACK:
  - locked=1.
  - Mismatch: err_pulse=1, err_cnt+1, sticky_err=1, good_run=0, go to FAULT.
  - Match: stay in TRACK.
- State FAULT:
  - locked=0.
  - Each mismatch: err_pulse=1, err_cnt+1, good_run=0.
  - Each match: good_run+1.
  - When good_run reaches RESYNC_N: go to TRACK, good_run=0.
  - Prediction always uses the observed prev_count, so a single skip costs one error, not a stream.
- wrap_pulse: asserted the cycle after a matched step with prev_en=1 and prev_count=all-ones (count_in=0). Asserted in TRACK and FAULT, never on a mismatch, never in UNSYNC.
- err_cnt saturates at 2^ERR_W-1. Further mismatches still pulse err_pulse.
- clr_err:
  - clr_err=1 zeroes err_cnt and sticky_err at the edge.
  - If a mismatch is detected on the same edge, clear wins. err_cnt=0 and sticky_err=0, but err_pulse still asserts.
  - State is not affected by clr_err.
- exp_count: registered copy of the prediction for the next edge. Reset value 0.
- Reset mid-operation (including in FAULT) returns everything to reset values immediately. Checking restarts via UNSYNC with no error counted for the discontinuity.
- en X/changes are sampled only at edges. en toggling every cycle is legal and checked per cycle.

Test Plan:
- Reset then en=1 with a correct counter for 20 cycles -> locked=1 from cycle 2. err_cnt=0. wrap_pulse exactly at count 7->0 steps (cycles 9 and 17 relative to release, given count starts at 0).
- en pattern 1,0,0,1,1 with a correct counter -> count 0,1,1,1,2,3 accepted. err_pulse never asserts.
- Force count_in 2->4 with en=1 -> err_pulse one cycle later, err_cnt=1, sticky_err=1, locked=0. After 4 correct steps locked=1 again.
- Stall: count held at 5 with en=1 for 3 cycles -> 3 err_pulses, err_cnt=3. Resync after 4 further good steps.
- ERR_W=2, inject 6 mismatches -> err_cnt saturates at 3, 6 err_pulses. clr_err coincident with 7th mismatch -> err_cnt=0, sticky_err=0, err_pulse=1.
- Assert rst low mid-FAULT with err_cnt=2 -> all outputs 0 immediately. After release, count jumps to 6 and no error is flagged.
